// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings for the RV32I control sequencers
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_PASSB = 2'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_HOLD   = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LUI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_ILLEGAL
    } instr_class_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// rtl/mc_opcode_decode.sv - opcode to instruction class, flags anything unsupported
module mc_opcode_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_e cls,
    output logic         illegal
);

    always_comb begin
        case (opcode)
            OP_R, OP_I: cls = CLS_ALU;
            OP_LUI:     cls = CLS_LUI;
            OP_LOAD:    cls = CLS_LOAD;
            OP_STORE:   cls = CLS_STORE;
            OP_BRANCH:  cls = CLS_BRANCH;
            OP_JAL:     cls = CLS_JAL;
            default:    cls = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle RV32I control sequencer with memory timeout trap
module mc_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       pc_load,
    output logic       ir_load,
    output logic       mdr_load,
    output logic       ab_load,
    output logic       alu_load,
    output logic       rf_we,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       trap
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic [7:0]   wait_cnt;
    logic [7:0]   wait_cnt_nxt;
    logic [7:0]   wait_inc;
    logic         timed_out;
    instr_class_e cls;
    logic         illegal;

    mc_opcode_decode u_decode (
        .opcode  (opcode),
        .cls     (cls),
        .illegal (illegal)
    );

    assign wait_inc  = sat_inc8(wait_cnt);
    assign timed_out = (wait_inc >= TIMEOUT_LIM);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        pc_load      = 1'b0;
        ir_load      = 1'b0;
        mdr_load     = 1'b0;
        ab_load      = 1'b0;
        alu_load     = 1'b0;
        rf_we        = 1'b0;
        pc_src       = PC_PLUS4;
        alu_op       = ALU_ADD;
        wb_sel       = WB_ALU;
        trap         = 1'b0;

        case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load   = 1'b1;
                    pc_load   = 1'b1;
                    state_nxt = ST_DECODE;
                end else begin
                    wait_cnt_nxt = wait_inc;
                    if (timed_out) state_nxt = ST_TRAP;
                end
            end
            // ALUOut captures PC+imm here so EXEC can jump without another add
            ST_DECODE: begin
                ab_load   = 1'b1;
                alu_load  = 1'b1;
                state_nxt = illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_ALU: begin
                        alu_load  = 1'b1;
                        alu_op    = ALU_FUNCT;
                        state_nxt = ST_WB;
                    end
                    CLS_LUI: begin
                        alu_load  = 1'b1;
                        alu_op    = ALU_PASSB;
                        state_nxt = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_load  = 1'b1;
                        state_nxt = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op    = ALU_SUB;
                        pc_load   = branch_taken;
                        pc_src    = branch_taken ? PC_ALUOUT : PC_HOLD;
                        state_nxt = ST_FETCH;
                    end
                    CLS_JAL: begin
                        alu_load  = 1'b1;
                        pc_load   = 1'b1;
                        pc_src    = PC_ALUOUT;
                        state_nxt = ST_WB;
                    end
                    default: state_nxt = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls == CLS_STORE);
                if (mem_ready) begin
                    mdr_load  = (cls == CLS_LOAD);
                    state_nxt = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else begin
                    wait_cnt_nxt = wait_inc;
                    if (timed_out) state_nxt = ST_TRAP;
                end
            end
            ST_WB: begin
                rf_we     = 1'b1;
                wb_sel    = (cls == CLS_LOAD) ? WB_MDR :
                            (cls == CLS_JAL)  ? WB_PC4 : WB_ALU;
                state_nxt = ST_FETCH;
            end
            ST_TRAP: trap = 1'b1;
            default: state_nxt = ST_TRAP;
        endcase

        // every fresh memory access starts its timeout window from zero
        if ((state_nxt == ST_FETCH || state_nxt == ST_MEM) && state_nxt != state)
            wait_cnt_nxt = 8'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for the multicycle control sequencer
module tb_mc_control_fsm;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, pc_load, ir_load, mdr_load, ab_load, alu_load, rf_we, trap;
    logic [1:0] pc_src, alu_op, wb_sel;

    int tests = 0;
    int failed = 0;

    mc_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .pc_load      (pc_load),
        .ir_load      (ir_load),
        .mdr_load     (mdr_load),
        .ab_load      (ab_load),
        .alu_load     (alu_load),
        .rf_we        (rf_we),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .wb_sel       (wb_sel),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    // pc_src only matters with pc_load, wb_sel only with rf_we
    logic [14:0] obs;
    assign obs = {mem_req, mem_we, pc_load, ir_load, mdr_load, ab_load, alu_load, rf_we,
                  (pc_load ? pc_src : 2'b00), alu_op, (rf_we ? wb_sel : 2'b00), trap};

    function automatic logic [14:0] o(input logic req, we, pcl, irl, mdrl, abl, alul, rfwe,
                                      input logic [1:0] pcs, aop, wbs, input logic trp);
        return {req, we, pcl, irl, mdrl, abl, alul, rfwe, pcs, aop, wbs, trp};
    endfunction

    localparam logic [14:0] V_ZERO   = 15'd0;
    localparam logic [14:0] F_WAIT   = o(1,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 0);
    localparam logic [14:0] F_RDY    = o(1,0,1,1,0,0,0,0, 2'd0, 2'd0, 2'd0, 0);
    localparam logic [14:0] DEC      = o(0,0,0,0,0,1,1,0, 2'd0, 2'd0, 2'd0, 0);
    localparam logic [14:0] EX_R     = o(0,0,0,0,0,0,1,0, 2'd0, 2'd2, 2'd0, 0);
    localparam logic [14:0] EX_LUI   = o(0,0,0,0,0,0,1,0, 2'd0, 2'd3, 2'd0, 0);
    localparam logic [14:0] EX_LS    = o(0,0,0,0,0,0,1,0, 2'd0, 2'd0, 2'd0, 0);
    localparam logic [14:0] EX_BR_T  = o(0,0,1,0,0,0,0,0, 2'd1, 2'd1, 2'd0, 0);
    localparam logic [14:0] EX_BR_N  = o(0,0,0,0,0,0,0,0, 2'd0, 2'd1, 2'd0, 0);
    localparam logic [14:0] EX_JAL   = o(0,0,1,0,0,0,1,0, 2'd1, 2'd0, 2'd0, 0);
    localparam logic [14:0] M_LD_W   = o(1,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 0);
    localparam logic [14:0] M_LD_R   = o(1,0,0,0,1,0,0,0, 2'd0, 2'd0, 2'd0, 0);
    localparam logic [14:0] M_ST     = o(1,1,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 0);
    localparam logic [14:0] WB_A     = o(0,0,0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 0);
    localparam logic [14:0] WB_L     = o(0,0,0,0,0,0,0,1, 2'd0, 2'd0, 2'd1, 0);
    localparam logic [14:0] WB_J     = o(0,0,0,0,0,0,0,1, 2'd0, 2'd0, 2'd2, 0);
    localparam logic [14:0] V_TRAP   = o(0,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 1);

    typedef struct {
        logic        ready;
        logic        taken;
        logic [14:0] exp;
        string       tag;
    } sb_t;

    sb_t sb[$];
    sb_t e;

    function automatic void push(input logic r, input logic t, input logic [14:0] x, input string tag);
        sb_t s;
        s.ready = r; s.taken = t; s.exp = x; s.tag = tag;
        sb.push_back(s);
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (obs !== V_ZERO || pc_src !== 2'd0 || wb_sel !== 2'd0) begin
            failed++;
            $display("FAIL reset.idle: got %b/%b/%b expected all zero", obs, pc_src, wb_sel);
        end
        do_reset();
        @(negedge clk);
        tests++;
        if (obs !== V_ZERO) begin
            failed++;
            $display("FAIL reset.release_idle: got %b expected %b", obs, V_ZERO);
        end
        push(0, 0, F_WAIT, "reset.first_fetch");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1; mem_ready = e.ready; branch_taken = e.taken;
            @(negedge clk);
            tests++;
            if (obs !== e.exp) begin failed++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.exp); end
        end
        // drop reset mid-cycle while the fetch request is outstanding
        #2 rst = 1'b0;
        #1;
        tests++;
        if (obs !== V_ZERO || pc_src !== 2'd0 || wb_sel !== 2'd0) begin
            failed++;
            $display("FAIL reset.async_drop: got %b expected %b", obs, V_ZERO);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== V_ZERO) begin
            failed++;
            $display("FAIL reset.mid_idle: got %b expected %b", obs, V_ZERO);
        end
        push(0, 0, F_WAIT, "reset.refetch");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1; mem_ready = e.ready; branch_taken = e.taken;
            @(negedge clk);
            tests++;
            if (obs !== e.exp) begin failed++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.exp); end
        end
    endtask

    task automatic test_alu();
        opcode = 7'b0110011;
        do_reset();
        push(1, 0, F_RDY, "add.fetch");
        push(1, 0, DEC,   "add.decode");
        push(1, 0, EX_R,  "add.exec");
        push(1, 0, WB_A,  "add.wb");
        push(1, 0, F_RDY, "add.next_fetch");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1; mem_ready = e.ready; branch_taken = e.taken;
            @(negedge clk);
            tests++;
            if (obs !== e.exp) begin failed++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.exp); end
        end
        opcode = 7'b0110111;
        do_reset();
        push(1, 0, F_RDY,  "lui.fetch");
        push(1, 0, DEC,    "lui.decode");
        push(1, 0, EX_LUI, "lui.exec");
        push(1, 0, WB_A,   "lui.wb");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1; mem_ready = e.ready; branch_taken = e.taken;
            @(negedge clk);
            tests++;
            if (obs !== e.exp) begin failed++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.exp); end
        end
    endtask

    task automatic test_load();
        opcode = 7'b0000011;
        do_reset();
        for (int i = 0; i < 3; i++) push(0, 0, F_WAIT, "load.fetch_wait");
        push(1, 0, F_RDY, "load.fetch_done");
        push(0, 0, DEC,   "load.decode");
        push(0, 0, EX_LS, "load.exec");
        for (int i = 0; i < 3; i++) push(0, 0, M_LD_W, "load.mem_wait");
        push(1, 0, M_LD_R, "load.mem_done");
        push(1, 0, WB_L,   "load.wb");
        push(0, 0, F_WAIT, "load.next_fetch");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1; mem_ready = e.ready; branch_taken = e.taken;
            @(negedge clk);
            tests++;
            if (obs !== e.exp) begin failed++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.exp); end
        end
    endtask

    task automatic test_branch();
        opcode = 7'b1100011;
        for (int t = 1; t >= 0; t--) begin
            do_reset();
            push(1, 1'(t), F_RDY, "branch.fetch");
            push(1, 1'(t), DEC,   "branch.decode");
            push(1, 1'(t), (t == 1) ? EX_BR_T : EX_BR_N, (t == 1) ? "branch.exec_taken" : "branch.exec_not_taken");
            push(0, 0, F_WAIT, "branch.next_fetch");
            while (sb.size() > 0) begin
                e = sb.pop_front();
                @(posedge clk); #1; mem_ready = e.ready; branch_taken = e.taken;
                @(negedge clk);
                tests++;
                if (obs !== e.exp) begin failed++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.exp); end
            end
        end
    endtask

    task automatic test_jal();
        opcode = 7'b1101111;
        do_reset();
        push(1, 0, F_RDY,  "jal.fetch");
        push(1, 0, DEC,    "jal.decode");
        push(1, 0, EX_JAL, "jal.exec");
        push(1, 0, WB_J,   "jal.wb");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1; mem_ready = e.ready; branch_taken = e.taken;
            @(negedge clk);
            tests++;
            if (obs !== e.exp) begin failed++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.exp); end
        end
    endtask

    task automatic test_store();
        opcode = 7'b0100011;
        do_reset();
        push(1, 0, F_RDY,  "store.fetch");
        push(1, 0, DEC,    "store.decode");
        push(1, 0, EX_LS,  "store.exec");
        push(0, 0, M_ST,   "store.mem_wait");
        push(1, 0, M_ST,   "store.mem_done");
        push(0, 0, F_WAIT, "store.next_fetch");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1; mem_ready = e.ready; branch_taken = e.taken;
            @(negedge clk);
            tests++;
            if (obs !== e.exp) begin failed++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.exp); end
        end
    endtask

    task automatic test_illegal();
        opcode = 7'b0000000;
        do_reset();
        push(1, 0, F_RDY,  "illegal.fetch");
        push(1, 0, DEC,    "illegal.decode");
        push(1, 0, V_TRAP, "illegal.trap");
        push(1, 1, V_TRAP, "illegal.trap_sticky");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1; mem_ready = e.ready; branch_taken = e.taken;
            @(negedge clk);
            tests++;
            if (obs !== e.exp) begin failed++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.exp); end
        end
    endtask

    task automatic test_timeout();
        opcode = 7'b0110011;
        do_reset();
        for (int i = 0; i < TO; i++) push(0, 0, F_WAIT, $sformatf("timeout.wait%0d", i));
        for (int i = 0; i < 3; i++) push(1, 0, V_TRAP, "timeout.trap_sticky");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1; mem_ready = e.ready; branch_taken = e.taken;
            @(negedge clk);
            tests++;
            if (obs !== e.exp) begin failed++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.exp); end
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (trap !== 1'b0 || obs !== V_ZERO) begin
            failed++;
            $display("FAIL timeout.rst_clears: got trap=%b obs=%b expected 0", trap, obs);
        end
        @(posedge clk); #1 rst = 1'b1;
        push(1, 0, F_RDY, "timeout.after_reset_fetch");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1; mem_ready = e.ready; branch_taken = e.taken;
            @(negedge clk);
            tests++;
            if (obs !== e.exp) begin failed++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.exp); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_jal();
        test_store();
        test_illegal();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
